axi4_write_monitor: RTL
=======================

# axi4_write_monitor

Synthesizable, parametrised AXI4 write-path monitor for the accelerator's memory-side AXI4 master ports. It tracks up to DEPTH outstanding AW requests, matches W beats to them in order, and confirms B responses. It reports per-burst completion records, running totals and sticky protocol-error flags. It observes fire strobes only and never back-pressures the bus. It replaces DPI-based write tracking wherever a synthesizable or FPGA-resident monitor is needed.

## Interface
- ADDR_BITS, 32, AW address width
- SIZE_BITS, 3, AW size field width
- LEN_BITS, 8, AW len field width (beats = len+1)
- DATA_BITS, 64, W data width; power of two, ≥8
- DEPTH, 4, outstanding-AW FIFO depth; power of two, ≥2
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- aw_fire  in  1  AW handshake this cycle
- aw_addr  in  ADDR_BITS  burst start address
- aw_size  in  SIZE_BITS  log2 bytes per beat
- aw_len  in  LEN_BITS  beats minus one
- w_fire  in  1  W handshake this cycle
- w_strb  in  DATA_BITS/8  byte strobes
- w_last  in  1  W last flag
- b_fire  in  1  B handshake this cycle
- b_resp  in  2  B response code
- busy  out  1  any AW queued, W burst in progress, or B pending
- outstanding  out  log2(DEPTH)+2  AW FIFO occupancy + B-pending count
- done_valid  out  1  one-cycle pulse: a W burst completed
- done_addr  out  ADDR_BITS  start address of completed burst
- done_beats  out  LEN_BITS+1  beats actually received
- done_bytes  out  24  bytes counted for completed burst
- total_bursts  out  32  completed W bursts since reset, wraps
- total_bytes  out  32  bytes counted since reset, wraps
- err  out  6  sticky error bits, cleared only by reset

## Operation
- AW FIFO of {addr,size,len}. aw_fire pushes. A push when full sets err[0] OVERFLOW and drops the entry. An entry with aw_size > log2(DATA_BITS/8) sets err[1] SIZE and is still queued.
- W FSM states: W_IDLE, W_DATA.
  - W_IDLE: on w_fire with a head entry (FIFO non-empty, or same-cycle aw_fire into an empty FIFO as bypass), the first beat is counted and the FSM goes to W_DATA, or completes immediately if the burst ends on that beat. w_fire with no head and no bypass sets err[2] W_NO_AW and the beat is ignored.
  - W_DATA: each w_fire increments beat_cnt.
- Burst end occurs at w_last or at beat_cnt==len, whichever comes first.
  - w_last with beat_cnt<len sets err[3] LAST_EARLY.
  - beat_cnt==len without w_last sets err[4] LAST_MISSING.
  - At burst end: pop the head, increment b_pending, emit the done record, return to W_IDLE.
- Byte counting: per beat, add 1<<aw_size (see Configuration).
- b_fire decrements b_pending.
  - b_fire with b_pending==0 sets err[5] B_UNEXPECTED; the counter is not decremented.
  - b_resp!=0 sets err[5] as well.
  - If a burst end and b_fire fall in the same cycle, the net b_pending change is 0.
- Same-cycle aw_fire and pop with a full FIFO: the pop happens first, so the push succeeds and there is no overflow.
- b_pending saturates at DEPTH+DEPTH; an increment at saturation sets err[0].

## Timing
- Reset values: every output is 0, FSM is W_IDLE, FIFO is empty, b_pending=0.
- done_* are registered: done_valid is high in the cycle after the completing w_fire edge. done_addr, done_beats and done_bytes hold their values until the next completion.
- total_bursts and total_bytes update on the same edge as done_valid; 32-bit wrap, no saturation.
- err bits set on the edge following the offending fire and stay set. outstanding and busy reflect post-edge state.
- Reset mid-burst drops the burst with no done pulse; reset overrides all fires in the same cycle.
- Zero-latency bypass: aw_fire and a single-beat w_fire with w_last in the same cycle produce done_valid on the next cycle and leave the FIFO empty.

## Configuration
- AXI4_WRITE_MONITOR_STRB_EN defined: bytes per beat = popcount(w_strb), and a beat with w_strb==0 is still counted as a beat.
- AXI4_WRITE_MONITOR_STRB_EN undefined: w_strb is ignored, and bytes per beat = 1<<aw_size of the head entry.

## Test plan
- Single burst, DATA_BITS=64: AW addr=0x1000 size=3 len=3, four W beats with last on the 4th, then b_fire resp=0 -> done_valid one cycle after the 4th beat with done_beats=4 and done_bytes=32; total_bursts=1; err=0; outstanding returns to 0 after B.
- Bypass: aw_fire len=0 and w_fire last in the same cycle -> done_valid next cycle with done_beats=1; FIFO empty; outstanding=1 until B.
- Overflow, DEPTH=4: five aw_fire with no W -> err[0]=1, outstanding=4; the 5th address never appears on done_addr.
- Last errors: len=3 with last on beat 2 -> err[3] and done_beats=2. Next len=1 with no last on beat 2 -> err[4] and done_beats=2.
- B errors: b_fire with nothing pending -> err[5] and outstanding unchanged. A valid burst followed by b_resp=2 -> err[5].
- STRB_EN: beats with strb 0xFF, 0x0F, 0x00, 0x01 at size=3 len=3 -> done_bytes=13 with the macro defined, 32 without it.

Source files
------------

// File: rtl/axi4_write_monitor_if.sv
// AXI4 write-path observation bundle: fire strobes plus the request, beat and
// response fields the monitor needs. The master modport drives, the slave listens.
interface axi4_write_monitor_if #(
    parameter int ADDR_BITS = 32,
    parameter int SIZE_BITS = 3,
    parameter int LEN_BITS  = 8,
    parameter int DATA_BITS = 64
);
    logic                   aw_fire;
    logic [ADDR_BITS-1:0]   aw_addr;
    logic [SIZE_BITS-1:0]   aw_size;
    logic [LEN_BITS-1:0]    aw_len;
    logic                   w_fire;
    logic [DATA_BITS/8-1:0] w_strb;
    logic                   w_last;
    logic                   b_fire;
    logic [1:0]             b_resp;

    modport master (
        output aw_fire, aw_addr, aw_size, aw_len,
        output w_fire, w_strb, w_last,
        output b_fire, b_resp
    );

    modport slave (
        input aw_fire, aw_addr, aw_size, aw_len,
        input w_fire, w_strb, w_last,
        input b_fire, b_resp
    );
endinterface

// File: rtl/axi4_write_monitor.sv
// Passive AXI4 write monitor: in-order AW/W matching, B accounting, burst records,
// totals and sticky error flags. Define AXI4_WRITE_MONITOR_STRB_EN to count bytes by strobe popcount.
module axi4_write_monitor #(
    parameter int ADDR_BITS = 32,
    parameter int SIZE_BITS = 3,
    parameter int LEN_BITS  = 8,
    parameter int DATA_BITS = 64,
    parameter int DEPTH     = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    axi4_write_monitor_if.slave       bus,
    output logic                      busy,
    output logic [$clog2(DEPTH)+1:0]  outstanding,
    output logic                      done_valid,
    output logic [ADDR_BITS-1:0]      done_addr,
    output logic [LEN_BITS:0]         done_beats,
    output logic [23:0]               done_bytes,
    output logic [31:0]               total_bursts,
    output logic [31:0]               total_bytes,
    output logic [5:0]                err
);

    localparam int PTR_BITS = $clog2(DEPTH);
    localparam int CNT_BITS = PTR_BITS + 1;
    localparam int OUT_BITS = PTR_BITS + 2;
    localparam logic [SIZE_BITS-1:0] MAX_SIZE = SIZE_BITS'($clog2(DATA_BITS / 8));
    localparam logic [CNT_BITS-1:0]  FIFO_FULL = CNT_BITS'(DEPTH);
    localparam logic [OUT_BITS-1:0]  B_MAX = OUT_BITS'(2 * DEPTH);

    typedef enum logic {W_IDLE, W_DATA} w_state_t;

    w_state_t state, next_state;

    logic [ADDR_BITS-1:0] fifo_addr [DEPTH];
    logic [SIZE_BITS-1:0] fifo_size [DEPTH];
    logic [LEN_BITS-1:0]  fifo_len  [DEPTH];
    logic [PTR_BITS-1:0]  wr_ptr, rd_ptr;
    logic [CNT_BITS-1:0]  fifo_count;
    logic [OUT_BITS-1:0]  b_pending;
    logic [LEN_BITS:0]    beat_cnt;
    logic [23:0]          byte_acc;

    logic                 fifo_full, fifo_empty, head_valid;
    logic [ADDR_BITS-1:0] head_addr;
    logic [SIZE_BITS-1:0] head_size;
    logic [LEN_BITS-1:0]  head_len;
    logic                 beat_take, last_idx, burst_end, push_ok, b_dec;
    logic [23:0]          beat_bytes;
    logic [5:0]           err_set;

    // An empty FIFO with a same-cycle AW lets the beat use the incoming request directly.
    always_comb begin
        fifo_full  = (fifo_count == FIFO_FULL);
        fifo_empty = (fifo_count == '0);
        head_valid = !fifo_empty || bus.aw_fire;
        head_addr  = fifo_empty ? bus.aw_addr : fifo_addr[rd_ptr];
        head_size  = fifo_empty ? bus.aw_size : fifo_size[rd_ptr];
        head_len   = fifo_empty ? bus.aw_len  : fifo_len[rd_ptr];
        beat_take  = bus.w_fire && head_valid;
        last_idx   = (beat_cnt == {1'b0, head_len});
        burst_end  = beat_take && (bus.w_last || last_idx);
        push_ok    = bus.aw_fire && (!fifo_full || burst_end);
        b_dec      = bus.b_fire && (b_pending != '0);
    end

`ifdef AXI4_WRITE_MONITOR_STRB_EN
    always_comb begin
        beat_bytes = '0;
        for (int i = 0; i < DATA_BITS / 8; i++) begin
            beat_bytes = beat_bytes + 24'(bus.w_strb[i]);
        end
    end
`else
    logic unused_strb;
    assign unused_strb = ^bus.w_strb;

    always_comb begin
        beat_bytes = 24'(1) << head_size;
    end
`endif

    always_comb begin
        err_set    = '0;
        err_set[0] = (bus.aw_fire && fifo_full && !burst_end)
                   || (burst_end && !b_dec && (b_pending == B_MAX));
        err_set[1] = bus.aw_fire && (bus.aw_size > MAX_SIZE);
        err_set[2] = bus.w_fire && !head_valid;
        err_set[3] = beat_take && bus.w_last && !last_idx;
        err_set[4] = beat_take && !bus.w_last && last_idx;
        err_set[5] = bus.b_fire && ((b_pending == '0) || (bus.b_resp != 2'b00));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= W_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            W_IDLE:  if (beat_take && !burst_end) next_state = W_DATA;
            W_DATA:  if (burst_end) next_state = W_IDLE;
            default: next_state = W_IDLE;
        endcase
    end

    // Storage has no reset; occupancy and pointers decide what is valid.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            fifo_addr[wr_ptr] <= bus.aw_addr;
            fifo_size[wr_ptr] <= bus.aw_size;
            fifo_len[wr_ptr]  <= bus.aw_len;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            b_pending    <= '0;
            beat_cnt     <= '0;
            byte_acc     <= '0;
            done_valid   <= 1'b0;
            done_addr    <= '0;
            done_beats   <= '0;
            done_bytes   <= '0;
            total_bursts <= '0;
            total_bytes  <= '0;
            err          <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (burst_end) rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !burst_end) begin
                fifo_count <= fifo_count + 1'b1;
            end else if (burst_end && !push_ok) begin
                fifo_count <= fifo_count - 1'b1;
            end

            if (burst_end && !b_dec) begin
                if (b_pending != B_MAX) b_pending <= b_pending + 1'b1;
            end else if (b_dec && !burst_end) begin
                b_pending <= b_pending - 1'b1;
            end

            done_valid <= burst_end;
            if (burst_end) begin
                beat_cnt     <= '0;
                byte_acc     <= '0;
                done_addr    <= head_addr;
                done_beats   <= beat_cnt + 1'b1;
                done_bytes   <= byte_acc + beat_bytes;
                total_bursts <= total_bursts + 32'd1;
                total_bytes  <= total_bytes + 32'(byte_acc + beat_bytes);
            end else if (beat_take) begin
                beat_cnt <= beat_cnt + 1'b1;
                byte_acc <= byte_acc + beat_bytes;
            end

            err <= err | err_set;
        end
    end

    assign outstanding = OUT_BITS'(fifo_count) + b_pending;
    assign busy        = !fifo_empty || (state == W_DATA) || (b_pending != '0);

endmodule
